// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB arbiter definitions: util-style width macros, source ids and the tie-break helper.
// Optional feature macro: CDB_RR_ARB_EN (round-robin tie break; fixed LSB priority when undefined).
`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 5
`endif
`ifndef VAL_WIDTH
`define VAL_WIDTH 32
`endif
`ifndef ROB_SIZE
`define ROB_SIZE 16
`endif
`ifndef CDB_SRC_RS
`define CDB_SRC_RS 1'b0
`endif
`ifndef CDB_SRC_LSB
`define CDB_SRC_LSB 1'b1
`endif

package cdb_arbiter_pkg;

  localparam logic SRC_RS  = `CDB_SRC_RS;
  localparam logic SRC_LSB = `CDB_SRC_LSB;

  // With both sources pending, round-robin hands the bus to whoever did not win last time.
  function automatic logic pick_src(input logic rs_ne, input logic lsb_ne,
                                    input logic rr_en, input logic last);
    logic sel;
    if (rs_ne && lsb_ne) begin
      sel = rr_en ? ~last : SRC_LSB;
    end else if (lsb_ne) begin
      sel = SRC_LSB;
    end else begin
      sel = SRC_RS;
    end
    return sel;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result FIFO: power-of-two storage with naturally wrapping pointers.
// Flush empties the FIFO and takes priority over push and pop.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_in,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the count decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: accepts RS and LSB results into small FIFOs and broadcasts one per rdy cycle.
// Optional feature macro: CDB_RR_ARB_EN (round-robin tie break instead of fixed LSB priority).
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int LAB_W      = `ROB_ID_WIDTH,
  parameter int VAL_W      = `VAL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             rs_valid,
  input  logic [LAB_W-1:0] rs_lab,
  input  logic [VAL_W-1:0] rs_val,
  output logic             rs_ready,
  input  logic             lsb_valid,
  input  logic [LAB_W-1:0] lsb_lab,
  input  logic [VAL_W-1:0] lsb_val,
  output logic             lsb_ready,
  output logic             cdb_valid,
  output logic [LAB_W-1:0] cdb_lab,
  output logic [VAL_W-1:0] cdb_val,
  output logic             cdb_src
);

  localparam int ENT_W = LAB_W + VAL_W;

  logic             active;
  logic             fifo_flush;
  logic             rs_push, rs_pop, rs_empty, rs_full;
  logic             lsb_push, lsb_pop, lsb_empty, lsb_full;
  logic [ENT_W-1:0] rs_head, lsb_head, grant_ent;
  logic             any_pending;
  logic             sel;

  assign active     = rdy_in & ~flush_in;
  assign fifo_flush = rdy_in & flush_in;

  // Label 0 is a handshake-only offer: accepted but never stored.
  assign rs_ready  = active & ~rs_full;
  assign lsb_ready = active & ~lsb_full;
  assign rs_push   = rs_valid & rs_ready & (rs_lab != '0);
  assign lsb_push  = lsb_valid & lsb_ready & (lsb_lab != '0);

  assign any_pending = ~rs_empty | ~lsb_empty;

`ifdef CDB_RR_ARB_EN
  logic last_grant;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      last_grant <= SRC_LSB;
    end else if (active && any_pending) begin
      last_grant <= sel;
    end
  end

  assign sel = pick_src(~rs_empty, ~lsb_empty, 1'b1, last_grant);
`else
  assign sel = pick_src(~rs_empty, ~lsb_empty, 1'b0, SRC_LSB);
`endif

  assign rs_pop    = active & ~rs_empty & (sel == SRC_RS);
  assign lsb_pop   = active & ~lsb_empty & (sel == SRC_LSB);
  assign grant_ent = (sel == SRC_LSB) ? lsb_head : rs_head;

  cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_rs_fifo (
    .clk   (clk),
    .rst_in(rst_in),
    .push  (rs_push),
    .pop   (rs_pop),
    .flush (fifo_flush),
    .din   ({rs_lab, rs_val}),
    .dout  (rs_head),
    .empty (rs_empty),
    .full  (rs_full)
  );

  cdb_src_fifo #(.DEPTH(FIFO_DEPTH), .W(ENT_W)) u_lsb_fifo (
    .clk   (clk),
    .rst_in(rst_in),
    .push  (lsb_push),
    .pop   (lsb_pop),
    .flush (fifo_flush),
    .din   ({lsb_lab, lsb_val}),
    .dout  (lsb_head),
    .empty (lsb_empty),
    .full  (lsb_full)
  );

  // Broadcast register holds through stalls so consumers see it in the next rdy cycle.
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cdb_valid <= 1'b0;
      cdb_lab   <= '0;
      cdb_val   <= '0;
      cdb_src   <= SRC_RS;
    end else if (rdy_in) begin
      if (flush_in || !any_pending) begin
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= 1'b1;
        cdb_lab   <= grant_ent[ENT_W-1:VAL_W];
        cdb_val   <= grant_ent[VAL_W-1:0];
        cdb_src   <= sel;
      end
    end
  end

endmodule
